// File: rtl/eater_pkg.sv
// Shared definitions for the boot loader that fills the CPU program RAM
// from a framed serial byte stream.
package eater_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         PROG_DEPTH  = 16;
    localparam int         PROG_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RELEASE
    } loader_state_t;

    // Running checksum is a plain modulo-256 byte sum.
    function automatic logic [7:0] sum8(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return a + b;
    endfunction

endpackage

// File: rtl/eater_loader_timer.sv
// Loadable down counter with synchronous clear; stops at zero.
// Used both for the inter-byte timeout and the CPU release delay.
module eater_loader_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_dec,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear wins over load, load wins over decrement.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/eater_loader.sv
// Frame-based program loader: sync byte, 16 data bytes, checksum.
// Holds the CPU in reset while loading and releases it after a good frame.
module eater_loader
    import eater_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int RELEASE_CYCLES  = 4,
    parameter int HOLD_UNTIL_LOAD = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic                   prog_we_o,
    output logic [PROG_ADDR_W-1:0] prog_addr_o,
    output logic [7:0]             prog_data_o,
    output logic                   cpu_reset_o,
    output logic                   loaded_o,
    output logic                   error_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [PROG_ADDR_W-1:0] LAST_IDX =
        PROG_ADDR_W'(PROG_DEPTH - 1);
    localparam logic CPU_RST_INIT = (HOLD_UNTIL_LOAD != 0);

    loader_state_t          r_state;
    logic [PROG_ADDR_W-1:0] r_idx;
    logic [7:0]             r_sum;
    logic                   r_prog_we;
    logic [PROG_ADDR_W-1:0] r_prog_addr;
    logic [7:0]             r_prog_data;
    logic                   r_cpu_reset;
    logic                   r_loaded;
    logic                   r_error;

    logic          w_ready;
    logic          w_accept;
    logic          w_is_sync;
    logic          w_in_frame;
    logic          w_sum_ok;
    logic          w_to_clear;
    logic          w_to_load;
    logic          w_to_dec;
    logic [TW-1:0] w_to_cnt;
    logic          w_to_expired;
    logic          w_rel_load;
    logic          w_rel_dec;
    logic [RW-1:0] w_rel_cnt;
    logic          w_rel_done;

    assign w_ready    = (r_state != ST_RELEASE);
    assign w_accept   = rx_valid_i & w_ready;
    assign w_is_sync  = (rx_data_i == SYNC_BYTE);
    assign w_in_frame = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_sum_ok   = (rx_data_i == r_sum);

    // Timeout restarts on the sync byte and on every data byte; the
    // checksum byte ends the frame, so the counter is cleared there.
    assign w_to_load  = ((r_state == ST_IDLE) && w_accept && w_is_sync)
                      || ((r_state == ST_LOAD) && w_accept);
    assign w_to_clear = (r_state == ST_CHECK) && w_accept;
    assign w_to_dec   = w_in_frame && !w_accept;

    // Counter reaches 1 after TIMEOUT_CYCLES-1 idle cycles; the idle
    // cycle in which it is seen at 1 is the last one allowed.
    assign w_to_expired = w_to_dec && (w_to_cnt == TW'(1));

    assign w_rel_load = (r_state == ST_CHECK) && w_accept && w_sum_ok;
    assign w_rel_dec  = (r_state == ST_RELEASE);
    assign w_rel_done = (r_state == ST_RELEASE) && (w_rel_cnt <= RW'(1));

    eater_loader_timer #(
        .W (TW)
    ) u_timeout (
        .i_clk   (clk_i),
        .i_rst   (reset_i),
        .i_clear (w_to_clear),
        .i_load  (w_to_load),
        .i_value (TW'(TIMEOUT_CYCLES)),
        .i_dec   (w_to_dec),
        .o_count (w_to_cnt)
    );

    eater_loader_timer #(
        .W (RW)
    ) u_release (
        .i_clk   (clk_i),
        .i_rst   (reset_i),
        .i_clear (1'b0),
        .i_load  (w_rel_load),
        .i_value (RW'(RELEASE_CYCLES)),
        .i_dec   (w_rel_dec),
        .o_count (w_rel_cnt)
    );

    // Loader FSM with registered RAM strobe and status outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_sum       <= '0;
            r_prog_we   <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_cpu_reset <= CPU_RST_INIT;
            r_loaded    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_prog_we <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_sync) begin
                        r_state     <= ST_LOAD;
                        r_idx       <= '0;
                        r_sum       <= '0;
                        r_error     <= 1'b0;
                        r_cpu_reset <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_prog_we   <= 1'b1;
                        r_prog_addr <= r_idx;
                        r_prog_data <= rx_data_i;
                        r_sum       <= sum8(r_sum, rx_data_i);
                        r_idx       <= r_idx + PROG_ADDR_W'(1);
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_CHECK;
                        end
                    end else if (w_to_expired) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        if (w_sum_ok) begin
                            r_state <= ST_RELEASE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_to_expired) begin
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (w_rel_done) begin
                        r_cpu_reset <= 1'b0;
                        r_loaded    <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready_o  = w_ready;
    assign prog_we_o   = r_prog_we;
    assign prog_addr_o = r_prog_addr;
    assign prog_data_o = r_prog_data;
    assign cpu_reset_o = r_cpu_reset;
    assign loaded_o    = r_loaded;
    assign error_o     = r_error;

endmodule

// File: tb/tb_eater_loader.sv
// Directed bench for eater_loader: frames, checksum errors, timeout,
// noise, mid-frame reset and backpressure during release.
module tb_eater_loader;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic       prog_we_o;
    logic [3:0] prog_addr_o;
    logic [7:0] prog_data_o;
    logic       cpu_reset_o;
    logic       loaded_o;
    logic       error_o;

    int n_checks = 0;
    int n_errors = 0;
    int wr_total = 0;
    logic [3:0] wa [0:511];
    logic [7:0] wd [0:511];
    logic [7:0] fr [16];

    eater_loader #(
        .TIMEOUT_CYCLES  (50),
        .RELEASE_CYCLES  (4),
        .HOLD_UNTIL_LOAD (1)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .prog_we_o   (prog_we_o),
        .prog_addr_o (prog_addr_o),
        .prog_data_o (prog_data_o),
        .cpu_reset_o (cpu_reset_o),
        .loaded_o    (loaded_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    // log every RAM write strobe
    always @(negedge clk_i) begin
        if (prog_we_o && wr_total < 512) begin
            wa[wr_total] = prog_addr_o;
            wd[wr_total] = prog_data_o;
            wr_total = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        w = 0;
        while (!rx_ready_o && w < 100) begin
            @(negedge clk_i);
            w = w + 1;
        end
        if (!rx_ready_o) begin
            check("send_ready", rx_ready_o, 1);
        end else begin
            @(posedge clk_i);
        end
        #1 rx_valid_i = 1'b0;
    endtask

    task automatic send_data();
        for (int i = 0; i < 16; i++) send(fr[i]);
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (cpu_reset_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n = n + 1;
        end
        check(tag, n, 4);
    endtask

    task automatic check_writes(input string tag, input int base,
                                input int n);
        int bad;
        bad = 0;
        check({tag, "_cnt"}, wr_total - base, n);
        for (int i = 0; i < n; i++) begin
            if (wa[base+i] !== 4'(i) || wd[base+i] !== fr[i]) bad++;
        end
        check({tag, "_data"}, bad, 0);
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        reset_i    = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) @(negedge clk_i);
        check("rst_ready", rx_ready_o, 1);
        check("rst_we", prog_we_o, 0);
        check("rst_addr", prog_addr_o, 0);
        check("rst_data", prog_data_o, 0);
        check("rst_cpu", cpu_reset_o, 1);
        check("rst_loaded", loaded_o, 0);
        check("rst_error", error_o, 0);
        reset_i = 1'b0;

        // bad checksum: 16 x 00, checksum 01
        for (int i = 0; i < 16; i++) fr[i] = 8'h00;
        base = wr_total;
        send(8'hA5);
        send_data();
        send(8'h01);
        check("bad_error", error_o, 1);
        check("bad_cpu", cpu_reset_o, 1);
        check("bad_loaded", loaded_o, 0);
        check("bad_ready", rx_ready_o, 1);
        check_writes("bad_wr", base, 16);

        // good frame 01..10, checksum 88
        for (int i = 0; i < 16; i++) fr[i] = 8'(i + 1);
        base = wr_total;
        send(8'hA5);
        check("good_errclr", error_o, 0);
        send_data();
        send(8'h88);
        check("good_ready_rel", rx_ready_o, 0);
        check("good_cpu_held", cpu_reset_o, 1);
        wait_release("good_rel_lat");
        check("good_loaded", loaded_o, 1);
        check("good_error", error_o, 0);
        check_writes("good_wr", base, 16);
        check("good_addr_hold", prog_addr_o, 4'hF);
        check("good_data_hold", prog_data_o, 8'h10);

        // timeout after 3 bytes
        fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33;
        base = wr_total;
        send(8'hA5);
        check("to_sync_cpu", cpu_reset_o, 1);
        for (int i = 0; i < 3; i++) send(fr[i]);
        n = 0;
        while (!error_o && n < 200) begin
            @(posedge clk_i);
            #1;
            n = n + 1;
        end
        check("to_lat", n, 50);
        check("to_cpu", cpu_reset_o, 1);
        check_writes("to_wr", base, 3);
        check("to_data_hold", prog_data_o, 8'h33);

        // recovery frame F0..FF, checksum 78
        for (int i = 0; i < 16; i++) fr[i] = 8'(8'hF0 + i);
        base = wr_total;
        send(8'hA5);
        check("rec_errclr", error_o, 0);
        send_data();
        send(8'h78);
        wait_release("rec_rel_lat");
        check("rec_cpu", cpu_reset_o, 0);
        check_writes("rec_wr", base, 16);

        // noise in idle, then 16 x A5 with checksum 50
        base = wr_total;
        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        @(negedge clk_i);
        check("noise_wr", wr_total - base, 0);
        check("noise_cpu", cpu_reset_o, 0);
        check("noise_err", error_o, 0);
        for (int i = 0; i < 16; i++) fr[i] = 8'hA5;
        send(8'hA5);
        check("wrap_sync_cpu", cpu_reset_o, 1);
        send_data();
        send(8'h50);
        wait_release("wrap_rel_lat");
        check_writes("wrap_wr", base, 16);

        // reset after the 8th data byte; pattern 7*i+1, checksum 58
        for (int i = 0; i < 16; i++) fr[i] = 8'(7 * i + 1);
        send(8'hA5);
        for (int i = 0; i < 8; i++) send(fr[i]);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check("mr_we", prog_we_o, 0);
        check("mr_addr", prog_addr_o, 0);
        check("mr_data", prog_data_o, 0);
        check("mr_loaded", loaded_o, 0);
        check("mr_error", error_o, 0);
        check("mr_cpu", cpu_reset_o, 1);
        check("mr_ready", rx_ready_o, 1);
        @(negedge clk_i);
        reset_i = 1'b0;
        base = wr_total;
        send(8'hA5);
        send_data();
        send(8'h58);
        wait_release("mr_rel_lat");
        check("mr_loaded2", loaded_o, 1);
        check_writes("mr_wr", base, 16);

        // backpressure: A5 held valid through release
        for (int i = 0; i < 16; i++) fr[i] = 8'(i + 1);
        send(8'hA5);
        send_data();
        send(8'h88);
        base = wr_total;
        rx_data_i  = 8'hA5;
        rx_valid_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!rx_ready_o && n < 20) begin
            n = n + 1;
            @(negedge clk_i);
        end
        check("bp_stall", n, 4);
        check("bp_released", cpu_reset_o, 0);
        @(posedge clk_i);
        #1 rx_valid_i = 1'b0;
        check("bp_newframe_cpu", cpu_reset_o, 1);
        check("bp_loaded", loaded_o, 1);
        send_data();
        send(8'h88);
        wait_release("bp_rel_lat");
        check_writes("bp_wr", base, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eater_loader.md
EATER_LOADER -- requirements
Module: eater_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: max idle cycles between bytes inside a frame.
REQ-002 Parameter RELEASE_CYCLES, default 4: cycles cpu_reset_o is held after a good frame; legal range >= 3.
REQ-003 Parameter HOLD_UNTIL_LOAD, default 1: when 1, the CPU is held in reset from reset until the first good frame.
REQ-004 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 rx_data_i  input  8  byte from the upstream serial receiver.
REQ-007 rx_valid_i  input  1  rx_data_i valid; a byte is accepted on a cycle with rx_valid_i & rx_ready_o.
REQ-008 rx_ready_o  output  1  loader can accept a byte.
REQ-009 prog_we_o  output  1  one-cycle write strobe to the CPU program RAM.
REQ-010 prog_addr_o  output  4  program RAM address.
REQ-011 prog_data_o  output  8  program RAM write data.
REQ-012 cpu_reset_o  output  1  drives the CPU reset_i; high holds the CPU in reset.
REQ-013 loaded_o  output  1  sticky: a good frame has completed since the last reset_i.
REQ-014 error_o  output  1  sticky: the last frame failed; cleared by the next sync byte.

Function
REQ-015 Frame format: sync byte 0xA5, then 16 data bytes for addresses 0..15 in order, then a checksum byte equal to the modulo-256 sum of the 16 data bytes.
REQ-016 States: IDLE, LOAD, CHECK, RELEASE.
REQ-017 IDLE: accepted bytes other than 0xA5 are discarded with no output change.
REQ-018 IDLE, accepted 0xA5: next state LOAD; byte index=0; sum=0; error_o=0; cpu_reset_o=1 from the next cycle.
REQ-019 LOAD, accepted byte d: prog_we_o=1 on the following cycle only, with prog_addr_o=index and prog_data_o=d; then sum+=d (8-bit wrap) and index+=1.
REQ-020 LOAD, after the byte with index 15 is accepted: next state CHECK; the 4-bit index wraps to 0 and is not otherwise used.
REQ-021 A data byte equal to 0xA5 inside LOAD is treated as data, not as a resync.
REQ-022 CHECK, accepted byte equal to sum: next state RELEASE; release counter loads RELEASE_CYCLES.
REQ-023 CHECK, accepted byte not equal to sum: error_o=1; cpu_reset_o stays 1; next state IDLE.
REQ-024 RELEASE: rx_ready_o=0; counter decrements each cycle; at 0, cpu_reset_o=0 and loaded_o=1 in the same cycle, and the next state is IDLE.
REQ-025 rx_ready_o=1 in IDLE, LOAD and CHECK.
REQ-026 In LOAD or CHECK, TIMEOUT_CYCLES consecutive cycles without an accepted byte: error_o=1; cpu_reset_o stays 1; next state IDLE; partial RAM contents are left as written.
REQ-027 The timeout counter clears on every accepted byte and on entry to LOAD.
REQ-028 cpu_reset_o is deasserted only in RELEASE; an error never releases the CPU.
REQ-029 prog_addr_o and prog_data_o hold their last values when prog_we_o=0.

Reset
REQ-030 reset_i asserted at any time, including mid-frame: state=IDLE, index=0, sum=0, all counters=0, prog_we_o=0, prog_addr_o=0, prog_data_o=0, loaded_o=0, error_o=0.
REQ-031 During and after reset_i, cpu_reset_o=HOLD_UNTIL_LOAD.

Structure
REQ-032 Shared package eater_pkg: loader state enum, SYNC_BYTE=8'hA5, PROG_DEPTH=16, PROG_ADDR_W=4.
REQ-033 Sub-module eater_loader_timer: loadable down/clear counter used for both the timeout and the release count.

Verification
REQ-034 Good frame: A5, 01..10, checksum 0x88 -> 16 single-cycle writes, addr 0..15 with data 01..10; cpu_reset_o falls 4 cycles after the checksum is accepted; loaded_o=1.
REQ-035 Bad checksum: A5, 16 x 00, checksum 01 -> 16 writes; error_o=1; cpu_reset_o stays 1; loaded_o=0.
REQ-036 Timeout (TIMEOUT_CYCLES=50): A5, 3 bytes, then silence -> error_o=1 at cycle 50 after the last byte; a following good frame clears error_o and releases the CPU.
REQ-037 Noise and wrap: 00 FF 3C, then A5 with 16 x A5 and checksum 0x50 -> noise ignored; A5 data bytes are written; the CPU is released.
REQ-038 reset_i pulsed after the 8th data byte -> all outputs return to their reset values; the next full frame loads correctly.
REQ-039 Backpressure: rx_valid_i held high with 0xA5 while in RELEASE -> no acceptance until IDLE, and that byte then starts a new frame.
